// File: rtl/door_pkg.sv
// Shared definitions for the door code-entry controller: FSM states,
// special keypad codes and LCD message selectors.
package door_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_GRANT = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_ENT = 4'hF;

    localparam logic [1:0] MSG_IDLE  = 2'b00;
    localparam logic [1:0] MSG_ENTRY = 2'b01;
    localparam logic [1:0] MSG_GRANT = 2'b10;
    localparam logic [1:0] MSG_ALARM = 2'b11;

    function automatic logic [1:0] msg_for(input state_t s);
        case (s)
            ST_ENTRY, ST_CHECK: msg_for = MSG_ENTRY;
            ST_GRANT:           msg_for = MSG_GRANT;
            ST_ALARM:           msg_for = MSG_ALARM;
            default:            msg_for = MSG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting cycle timer: load a value, count down to zero while enabled,
// saturating at zero; done is high whenever the count is zero.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad door-code controller with grant and lockout timing.
// Optional feature: define ENTRY_TIMEOUT_EN for an ENTRY inactivity timeout.
module code_entry_ctrl
    import door_pkg::*;
#(
    parameter logic [15:0] CODE        = 16'h4693,
    parameter int          MAX_TRIES   = 3,
    parameter int          TIMEOUT_CYC = 250000000,
    parameter int          GRANT_CYC   = 150000000,
    parameter int          LOCKOUT_CYC = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       presence,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] digit_count,
    output logic [1:0] tries,
    output logic [1:0] msg_sel
);

    localparam int MAX_GL  = (GRANT_CYC > LOCKOUT_CYC) ? GRANT_CYC : LOCKOUT_CYC;
    localparam int MAX_CYC = (TIMEOUT_CYC > MAX_GL) ? TIMEOUT_CYC : MAX_GL;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The timer is loaded with N-1 so that a state held until done lasts N cycles.
    localparam logic [TW-1:0] GRANT_LOAD   = TW'(GRANT_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
`ifdef ENTRY_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
`endif

    state_t         state, state_n;
    logic [15:0]    buffer, buffer_n;
    logic [2:0]     count_n;
    logic [1:0]     tries_n;
    logic           tmr_load, tmr_count, tmr_done;
    logic [TW-1:0]  tmr_val;

    // GRANT, ALARM and the ENTRY timeout never overlap, so one timer serves all three.
    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    always_comb begin
        state_n   = state;
        buffer_n  = buffer;
        count_n   = digit_count;
        tries_n   = tries;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_count = 1'b0;

        case (state)
            ST_IDLE: begin
                if (presence) begin
                    state_n  = ST_ENTRY;
                    buffer_n = '0;
                    count_n  = '0;
`ifdef ENTRY_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
`endif
                end
            end

            ST_ENTRY: begin
                if (!presence) begin
                    state_n  = ST_IDLE;
                    buffer_n = '0;
                    count_n  = '0;
                end else if (key_valid) begin
`ifdef ENTRY_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
`endif
                    if (key_code <= 4'd9) begin
                        if (digit_count < 3'd4) begin
                            buffer_n = {buffer[11:0], key_code};
                            count_n  = digit_count + 3'd1;
                        end
                    end else if (key_code == KEY_CLR) begin
                        buffer_n = '0;
                        count_n  = '0;
                    end else if (key_code == KEY_ENT) begin
                        state_n = ST_CHECK;
                    end
                end else begin
`ifdef ENTRY_TIMEOUT_EN
                    if (tmr_done) begin
                        state_n  = ST_IDLE;
                        buffer_n = '0;
                        count_n  = '0;
                    end else begin
                        tmr_count = 1'b1;
                    end
`endif
                end
            end

            ST_CHECK: begin
                if (digit_count == 3'd4 && buffer == CODE) begin
                    state_n  = ST_GRANT;
                    tries_n  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = GRANT_LOAD;
                end else if (int'(tries) + 1 == MAX_TRIES) begin
                    state_n  = ST_ALARM;
                    tries_n  = tries + 2'd1;
                    tmr_load = 1'b1;
                    tmr_val  = LOCKOUT_LOAD;
                end else begin
                    state_n  = ST_ENTRY;
                    tries_n  = tries + 2'd1;
                    buffer_n = '0;
                    count_n  = '0;
`ifdef ENTRY_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
`endif
                end
            end

            ST_GRANT: begin
                if (tmr_done) begin
                    state_n  = ST_IDLE;
                    buffer_n = '0;
                    count_n  = '0;
                end else begin
                    tmr_count = 1'b1;
                end
            end

            ST_ALARM: begin
                if (tmr_done) begin
                    state_n  = ST_IDLE;
                    tries_n  = '0;
                    buffer_n = '0;
                    count_n  = '0;
                end else begin
                    tmr_count = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            buffer      <= '0;
            digit_count <= '0;
            tries       <= '0;
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            msg_sel     <= MSG_IDLE;
        end else begin
            state       <= state_n;
            buffer      <= buffer_n;
            digit_count <= count_n;
            tries       <= tries_n;
            unlock      <= (state_n == ST_GRANT);
            alarm       <= (state_n == ST_ALARM);
            msg_sel     <= msg_for(state_n);
        end
    end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Self-checking bench for code_entry_ctrl: directed scenarios plus random
// keypad traffic compared every cycle against a behavioural door model.
module tb_code_entry_ctrl;

    localparam logic [15:0] CODE        = 16'h4693;
    localparam int          MAX_TRIES   = 3;
    localparam int          TIMEOUT_CYC = 12;
    localparam int          GRANT_CYC   = 5;
    localparam int          LOCKOUT_CYC = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       presence = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       unlock, alarm;
    logic [2:0] digit_count;
    logic [1:0] tries, msg_sel;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    code_entry_ctrl #(
        .CODE        (CODE),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GRANT_CYC   (GRANT_CYC),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .presence    (presence),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .unlock      (unlock),
        .alarm       (alarm),
        .digit_count (digit_count),
        .tries       (tries),
        .msg_sel     (msg_sel)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the door should be doing, phase by phase.
    localparam int P_IDLE = 0, P_ENTRY = 1, P_CHECK = 2, P_GRANT = 3, P_ALARM = 4;
    int m_phase = P_IDLE;
    int m_tries = 0;
    int m_left  = 0;
    int m_quiet = 0;
    int m_digits[$];

    function automatic bit codeMatches();
        if (m_digits.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (m_digits[i] != int'((CODE >> (4 * (3 - i))) & 16'hF)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = P_IDLE; m_tries = 0; m_left = 0; m_quiet = 0; m_digits = {};
        end else begin
            case (m_phase)
                P_IDLE: if (presence) begin m_phase = P_ENTRY; m_digits = {}; m_quiet = 0; end
                P_ENTRY: begin
                    if (!presence) begin
                        m_phase = P_IDLE; m_digits = {};
                    end else if (key_valid) begin
                        m_quiet = 0;
                        if (key_code <= 9 && m_digits.size() < 4) m_digits.push_back(int'(key_code));
                        else if (key_code == 4'hE) m_digits = {};
                        else if (key_code == 4'hF) m_phase = P_CHECK;
                    end else begin
                        m_quiet++;
`ifdef ENTRY_TIMEOUT_EN
                        if (m_quiet == TIMEOUT_CYC) begin m_phase = P_IDLE; m_digits = {}; end
`endif
                    end
                end
                P_CHECK: begin
                    if (codeMatches()) begin
                        m_tries = 0; m_phase = P_GRANT; m_left = GRANT_CYC;
                    end else begin
                        m_tries++;
                        if (m_tries == MAX_TRIES) begin m_phase = P_ALARM; m_left = LOCKOUT_CYC; end
                        else begin m_phase = P_ENTRY; m_digits = {}; m_quiet = 0; end
                    end
                end
                P_GRANT: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_IDLE; m_digits = {}; end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_IDLE; m_digits = {}; m_tries = 0; end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("unlock", 32'(unlock), int'(m_phase == P_GRANT));
            checkOutput("alarm", 32'(alarm), int'(m_phase == P_ALARM));
            checkOutput("msg_sel", 32'(msg_sel),
                        (m_phase == P_IDLE) ? 0 : (m_phase == P_GRANT) ? 2 : (m_phase == P_ALARM) ? 3 : 1);
            checkOutput("digit_count", 32'(digit_count), m_digits.size());
            checkOutput("tries", 32'(tries), m_tries);
        end
    end

    task automatic applyStimulus(input logic p, input logic kv, input logic [3:0] kc);
        @(negedge clk);
        presence  = p;
        key_valid = kv;
        key_code  = kc;
    endtask

    task automatic pressKey(input logic [3:0] k);
        applyStimulus(1'b1, 1'b1, k);
        applyStimulus(1'b1, 1'b0, 4'h0);
    endtask

    // Keys are packed as nibbles, first key in the most significant used nibble.
    task automatic enterSeq(input logic [31:0] seq, input int n);
        applyStimulus(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < n; i++) pressKey(seq[4 * (n - 1 - i) +: 4]);
    endtask

    // Length of the next run of the selected output (0 unlock, 1 alarm, 2 entry msg).
    task automatic measure(input int which, output int len);
        logic v;
        len = 0;
        for (int i = 0; i < 200; i++) begin
            v = (which == 0) ? unlock : (which == 1) ? alarm : (msg_sel == 2'b01);
            if (v) len++;
            else if (len > 0) break;
            applyStimulus(1'b1, 1'b0, 4'h0);
        end
    endtask

    initial begin
        int len;
        int idx;
        logic [3:0] pattern [5];
        pattern[0] = 4'h4; pattern[1] = 4'h6; pattern[2] = 4'h9; pattern[3] = 4'h3; pattern[4] = 4'hF;

        repeat (3) @(negedge clk);
        checkOutput("rst_unlock", 32'(unlock), 0);
        checkOutput("rst_alarm", 32'(alarm), 0);
        checkOutput("rst_msg", 32'(msg_sel), 0);
        checkOutput("rst_count", 32'(digit_count), 0);
        checkOutput("rst_tries", 32'(tries), 0);
        cmp_en = 1'b1;
        reset = 1'b1;

        // Correct code opens the door.
        enterSeq(32'h4693F, 5);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t1_msg", 32'(msg_sel), 2);
        checkOutput("t1_tries", 32'(tries), 0);
        measure(0, len);
        checkOutput("t1_unlock_len", 32'(len), GRANT_CYC);

        // Three wrong codes end in a lockout.
        for (int t = 1; t <= 3; t++) begin
            enterSeq(32'h1234F, 5);
            applyStimulus(1'b1, 1'b0, 4'h0);
            checkOutput("t2_tries", 32'(tries), t);
        end
        checkOutput("t2_alarm", 32'(alarm), 1);
        measure(1, len);
        checkOutput("t2_alarm_len", 32'(len), LOCKOUT_CYC);
        checkOutput("t2_tries_after", 32'(tries), 0);
        checkOutput("t2_msg_after", 32'(msg_sel), 0);

        // Clear mid-entry, then a fifth digit that must be ignored.
        enterSeq(32'h46E4693F, 8);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t3_clr_msg", 32'(msg_sel), 2);
        measure(0, len);
        checkOutput("t3_clr_len", 32'(len), GRANT_CYC);
        enterSeq(32'h46937, 5);
        checkOutput("t3_fifth_count", 32'(digit_count), 4);
        pressKey(4'hF);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t3_fifth_msg", 32'(msg_sel), 2);
        measure(0, len);
        checkOutput("t3_fifth_len", 32'(len), GRANT_CYC);

        // Presence drop beats a simultaneous key strobe.
        enterSeq(32'h12, 2);
        checkOutput("t4_count_before", 32'(digit_count), 2);
        applyStimulus(1'b0, 1'b1, 4'h5);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("t4_msg", 32'(msg_sel), 0);
        checkOutput("t4_count", 32'(digit_count), 0);

        // Reset in the middle of a grant.
        enterSeq(32'h4693F, 5);
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t5_unlock_before", 32'(unlock), 1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h0);
        reset = 1'b1;
        checkOutput("t5_unlock_after", 32'(unlock), 0);
        checkOutput("t5_msg_after", 32'(msg_sel), 0);

        // Idle ENTRY: times out only when the feature is built in.
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        measure(2, len);
`ifdef ENTRY_TIMEOUT_EN
        checkOutput("t6_timeout_len", 32'(len), TIMEOUT_CYC);
`else
        checkOutput("t6_no_timeout", 32'(len > 4 * TIMEOUT_CYC), 1);
`endif
        applyStimulus(1'b0, 1'b0, 4'h0);

        // Random traffic biased toward the real code so grants still happen.
        idx = 0;
        for (int i = 0; i < 3000; i++) begin
            logic p, kv;
            logic [3:0] kc;
            p  = ($urandom_range(0, 19) != 0);
            kv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 7) begin
                kc = pattern[idx];
                if (kv) idx = (idx + 1) % 5;
            end else begin
                kc = 4'($urandom_range(0, 15));
            end
            applyStimulus(p, kv, kc);
            reset = ($urandom_range(0, 999) != 0);
        end
        applyStimulus(1'b0, 1'b0, 4'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
